// File: rtl/sarray_mem_resp_if.sv
// sarray_mem_resp_if: ar/r/aw bundle between the systolic array and its backing memory.
// slave = memory side (accepts ar/aw, drives r); master = requester side.
interface sarray_mem_resp_if #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 256,
   parameter int OSTD_DEPTH  = 8
);
   localparam int CW = $clog2(OSTD_DEPTH + 1);

   logic                  ar_valid_i;
   logic                  ar_ready_o;
   logic [ADDR_WIDTH-1:0] ar_addr_i;
   logic                  r_valid_o;
   logic                  r_ready_i;
   logic [DATA_WIDTH-1:0] r_data_o;
   logic                  aw_valid_i;
   logic                  aw_ready_o;
   logic [ADDR_WIDTH-1:0] aw_addr_i;
   logic [DATA_WIDTH-1:0] aw_data_i;
   logic [CW-1:0]         ostd_cnt_o;

   modport slave (
      input  ar_valid_i, ar_addr_i, r_ready_i,
      input  aw_valid_i, aw_addr_i, aw_data_i,
      output ar_ready_o, r_valid_o, r_data_o,
      output aw_ready_o, ostd_cnt_o
   );

   modport master (
      output ar_valid_i, ar_addr_i, r_ready_i,
      output aw_valid_i, aw_addr_i, aw_data_i,
      input  ar_ready_o, r_valid_o, r_data_o,
      input  aw_ready_o, ostd_cnt_o
   );
endinterface

// File: rtl/sarray_mem_resp.sv
// sarray_mem_resp: word memory with fixed read latency and an in-order outstanding-read queue.
// Ports: clk, rst (sync, active-high), bus (slave: ar/r read channel, aw write channel, ostd count).
module sarray_mem_resp #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 256,
   parameter int DEPTH_WORDS = 64,
   parameter int OSTD_DEPTH  = 8,
   parameter int RD_LATENCY  = 4
) (
   input logic clk,
   input logic rst,
   sarray_mem_resp_if.slave bus
);
   localparam int OFS = $clog2(DATA_WIDTH / 8);
   localparam int IW  = $clog2(DEPTH_WORDS);
   localparam int PW  = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;
   localparam int CW  = $clog2(OSTD_DEPTH + 1);
   localparam int TW  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   logic [DATA_WIDTH-1:0] mem    [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] q_data [OSTD_DEPTH];
   logic [TW-1:0]         q_tmr  [OSTD_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         count;

   logic [IW-1:0]         ar_idx;
   logic [IW-1:0]         aw_idx;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  r_hs;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_addr;

   assign ar_idx = bus.ar_addr_i[OFS +: IW];
   assign aw_idx = bus.aw_addr_i[OFS +: IW];

   // Offset and alias bits of both addresses are intentionally dropped.
   assign unused_addr = ^{bus.ar_addr_i, bus.aw_addr_i};

   assign bus.aw_ready_o = !rst;
   assign bus.ar_ready_o = !rst && (count < CW'(OSTD_DEPTH));
   assign bus.ostd_cnt_o = count;

   assign aw_hs = bus.aw_valid_i && bus.aw_ready_o;
   assign ar_hs = bus.ar_valid_i && bus.ar_ready_o;

   assign r_valid = !rst && (count != '0) && (q_tmr[head] == '0);
   assign r_hs    = r_valid && bus.r_ready_i;

   assign bus.r_valid_o = r_valid;
   assign bus.r_data_o  = r_valid ? q_data[head] : '0;

   // Same-cycle write to the word being read returns the new data.
   assign rd_word = (aw_hs && (aw_idx == ar_idx)) ?
                    bus.aw_data_i : mem[ar_idx];

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(OSTD_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (aw_hs) begin
         mem[aw_idx] <= bus.aw_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < OSTD_DEPTH; i++) begin
            q_tmr[i] <= '0;
         end
      end else begin
         // All timers age each cycle, even behind a stalled head.
         for (int i = 0; i < OSTD_DEPTH; i++) begin
            if (q_tmr[i] != '0) begin
               q_tmr[i] <= q_tmr[i] - 1'b1;
            end
         end
         if (ar_hs) begin
            q_data[tail] <= rd_word;
            q_tmr[tail]  <= TW'(RD_LATENCY - 1);
            tail         <= nxt(tail);
         end
         if (r_hs) begin
            head <= nxt(head);
         end
         unique case ({ar_hs, r_hs})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_sarray_mem_resp.sv
// tb_sarray_mem_resp: directed steps with a response scoreboard for sarray_mem_resp.
// Drives the master side of the interface; checks latency, ordering, backpressure, aliasing, reset.
module tb_sarray_mem_resp;
   localparam int AW  = 32;
   localparam int DW  = 256;
   localparam int DEP = 64;
   localparam int OST = 8;
   localparam int LAT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sarray_mem_resp_if #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OSTD_DEPTH(OST)
   ) bus ();

   sarray_mem_resp #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_WORDS(DEP),
      .OSTD_DEPTH(OST), .RD_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int rx     = 0;

   logic [DW-1:0] model [DEP];
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] e;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int widx(input logic [AW-1:0] a);
      return int'((a / 32) % DEP);
   endfunction

   // Reference memory + in-order expected-response queue.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.r_valid_o && bus.r_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_resp", DW'(bus.r_valid_o), '0);
            end else begin
               e = exp_q.pop_front();
               chk("resp_data", bus.r_data_o, e);
               rx++;
            end
         end
         if (bus.ar_valid_i && bus.ar_ready_o) begin
            if (bus.aw_valid_i && bus.aw_ready_o &&
                widx(bus.aw_addr_i) == widx(bus.ar_addr_i))
               exp_q.push_back(bus.aw_data_i);
            else
               exp_q.push_back(model[widx(bus.ar_addr_i)]);
         end
         if (bus.aw_valid_i && bus.aw_ready_o)
            model[widx(bus.aw_addr_i)] = bus.aw_data_i;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.aw_valid_i = 1'b1;
      bus.aw_addr_i  = a;
      bus.aw_data_i  = d;
      step();
      bus.aw_valid_i = 1'b0;
   endtask

   // Bounded wait for r_valid; returns cycles waited (1 = next cycle).
   task automatic wait_valid(output int lat);
      bit done = 0;
      lat = 0;
      while (!done && lat < 20) begin
         lat++;
         @(negedge clk);
         if (bus.r_valid_o) done = 1;
         else step();
      end
   endtask

   task automatic rd_chk(input string tag, input logic [AW-1:0] a,
                         input logic [DW-1:0] expv);
      int lat;
      bus.ar_valid_i = 1'b1;
      bus.ar_addr_i  = a;
      @(negedge clk);
      chk({tag, "_ar_ready"}, DW'(bus.ar_ready_o), DW'(1));
      step();
      bus.ar_valid_i = 1'b0;
      wait_valid(lat);
      chk({tag, "_latency"}, DW'(lat), DW'(LAT));
      chk({tag, "_data"}, bus.r_data_o, expv);
      step();
   endtask

   int acc;
   int lat;
   int stale;
   int rx0;
   logic [DW-1:0] fill;

   initial begin
      bus.ar_valid_i = 1'b0;
      bus.ar_addr_i  = '0;
      bus.aw_valid_i = 1'b0;
      bus.aw_addr_i  = '0;
      bus.aw_data_i  = '0;
      bus.r_ready_i  = 1'b1;
      fill = {16{16'hA5A5}};

      // Reset
      rst = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("rst_ar_ready", DW'(bus.ar_ready_o), '0);
      chk("rst_aw_ready", DW'(bus.aw_ready_o), '0);
      chk("rst_r_valid",  DW'(bus.r_valid_o), '0);
      chk("rst_r_data",   bus.r_data_o, '0);
      chk("rst_ostd",     DW'(bus.ostd_cnt_o), '0);
      step();
      rst = 1'b0;

      // 1: single read, latency and outstanding count
      wr(32'h40, fill);
      bus.ar_valid_i = 1'b1;
      bus.ar_addr_i  = 32'h40;
      @(negedge clk);
      chk("t1_ar_ready", DW'(bus.ar_ready_o), DW'(1));
      step();
      bus.ar_valid_i = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t1_ostd", DW'(bus.ostd_cnt_o), DW'(1));
         chk("t1_r_valid", DW'(bus.r_valid_o), DW'(k == 4));
         if (k == 4) chk("t1_data", bus.r_data_o, fill);
         step();
      end
      @(negedge clk);
      chk("t1_ostd_after", DW'(bus.ostd_cnt_o), '0);
      chk("t1_idle_data", bus.r_data_o, '0);
      step();

      // 2: back-to-back reads, no bubbles
      for (int i = 0; i < 8; i++) wr(AW'(i * 32), DW'(i * 'h11));
      for (int c = 0; c < 16; c++) begin
         if (c < 8) begin
            bus.ar_valid_i = 1'b1;
            bus.ar_addr_i  = AW'(c * 32);
         end else begin
            bus.ar_valid_i = 1'b0;
         end
         @(negedge clk);
         chk("t2_r_valid", DW'(bus.r_valid_o), DW'(c >= 4 && c < 12));
         if (c >= 4 && c < 12)
            chk("t2_data", bus.r_data_o, DW'((c - 4) * 'h11));
         step();
      end

      // 3: full queue under backpressure
      wr(32'h100, DW'('h88));
      wr(32'h120, DW'('h99));
      rx0 = rx;
      bus.r_ready_i  = 1'b0;
      acc = 0;
      bus.ar_valid_i = 1'b1;
      bus.ar_addr_i  = '0;
      repeat (12) begin
         @(negedge clk);
         if (bus.ar_ready_o) acc++;
         step();
         bus.ar_addr_i = AW'(acc * 32);
      end
      @(negedge clk);
      chk("t3_accepted", DW'(acc), DW'(OST));
      chk("t3_ar_ready_full", DW'(bus.ar_ready_o), '0);
      chk("t3_ostd_full", DW'(bus.ostd_cnt_o), DW'(OST));
      step();
      bus.r_ready_i = 1'b1;
      @(negedge clk);
      chk("t3_ar_ready_pop_cyc", DW'(bus.ar_ready_o), '0);
      chk("t3_r_valid", DW'(bus.r_valid_o), DW'(1));
      step();
      @(negedge clk);
      chk("t3_ar_ready_next", DW'(bus.ar_ready_o), DW'(1));
      if (bus.ar_ready_o) acc++;
      step();
      bus.ar_addr_i = AW'(acc * 32);
      @(negedge clk);
      if (bus.ar_ready_o) acc++;
      step();
      bus.ar_valid_i = 1'b0;
      chk("t3_accepted_all", DW'(acc), DW'(10));
      lat = 0;
      while (bus.ostd_cnt_o != '0 && lat < 40) begin
         step();
         lat++;
      end
      @(negedge clk);
      chk("t3_drained", DW'(bus.ostd_cnt_o), '0);
      chk("t3_rx_count", DW'(rx - rx0), DW'(10));
      step();

      // 4: same-cycle write forwarding
      wr(32'h80, DW'('h1234));
      bus.aw_valid_i = 1'b1;
      bus.aw_addr_i  = 32'h80;
      bus.aw_data_i  = DW'('hBEEF);
      bus.ar_valid_i = 1'b1;
      bus.ar_addr_i  = 32'h80;
      step();
      bus.aw_valid_i = 1'b0;
      bus.ar_valid_i = 1'b0;
      wait_valid(lat);
      chk("t4_latency", DW'(lat), DW'(LAT));
      chk("t4_fwd_data", bus.r_data_o, DW'('hBEEF));
      step();
      rd_chk("t4_reread", 32'h80, DW'('hBEEF));

      // 5: aliasing and ignored offset bits
      wr(32'h0, DW'('hCAFE));
      rd_chk("t5_alias", 32'h800, DW'('hCAFE));
      rd_chk("t5_offset", 32'h1F, DW'('hCAFE));

      // 6: reset with reads outstanding
      bus.r_ready_i = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.ar_valid_i = 1'b1;
         bus.ar_addr_i  = AW'(i * 32);
         step();
      end
      bus.ar_valid_i = 1'b0;
      repeat (5) step();
      @(negedge clk);
      chk("t6_ostd_pre", DW'(bus.ostd_cnt_o), DW'(3));
      chk("t6_stalled_valid", DW'(bus.r_valid_o), DW'(1));
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_r_valid", DW'(bus.r_valid_o), '0);
      chk("t6_rst_r_data", bus.r_data_o, '0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_ostd_post", DW'(bus.ostd_cnt_o), '0);
      chk("t6_r_valid_post", DW'(bus.r_valid_o), '0);
      step();
      bus.r_ready_i = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.r_valid_o) stale++;
         step();
      end
      chk("t6_stale", DW'(stale), '0);
      rd_chk("t6_fresh", 32'hA0, DW'('h55));

      repeat (2) step();
      chk("sb_empty", DW'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
